// File: rtl/adc_pkg.sv
// Shared types and default constants for the serial ADC capture front end.
package adc_pkg;

  typedef enum logic {QUIET, CONVERT} state_t;

  localparam int DEF_WIDTH         = 12;
  localparam int DEF_FRAME_BITS    = 16;
  localparam int DEF_LEAD_BITS     = 4;
  localparam int DEF_CLK_DIV       = 2;
  localparam int DEF_QUIET_PERIODS = 4;

  function automatic int period_of(input int clk_div);
    return 2 * clk_div;
  endfunction

  localparam int DEF_PERIOD = period_of(DEF_CLK_DIV);

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: low half first, then high half, with sample and
// end-of-period ticks. Holds adc_clk high while disabled.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic adc_clk,
  output logic rise_tick,
  output logic period_tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          active;
  logic          half_end;

  always_comb begin
    half_end    = active && (cnt == HALF_LAST);
    rise_tick   = half_end && !adc_clk;
    period_tick = half_end && adc_clk;
  end

  // enable is a lookahead (next cycle is in a frame), so the first frame
  // cycle already shows adc_clk low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      active  <= 1'b0;
      adc_clk <= 1'b1;
    end else if (!enable) begin
      cnt     <= '0;
      active  <= 1'b0;
      adc_clk <= 1'b1;
    end else if (!active || period_tick) begin
      cnt     <= '0;
      active  <= 1'b1;
      adc_clk <= 1'b0;
    end else if (half_end) begin
      cnt     <= '0;
      adc_clk <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_serial_capture.sv
// Serial ADC front end: frames chip select, shifts in one sample per
// conversion and strobes ready when the parallel sample is updated.
module adc_serial_capture
  import adc_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int FRAME_BITS    = DEF_FRAME_BITS,
  parameter int LEAD_BITS     = DEF_LEAD_BITS,
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int QUIET_PERIODS = DEF_QUIET_PERIODS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adc_sd,
  output logic             adc_clk,
  output logic             adc_cs,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  localparam int PERIOD       = period_of(CLK_DIV);
  localparam int QUIET_CYCLES = QUIET_PERIODS * PERIOD;
  localparam int QW           = cnt_width(QUIET_CYCLES);
  localparam int BW           = cnt_width(FRAME_BITS);

  localparam logic [QW-1:0] QUIET_LAST  = QW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SHIFT_FIRST = BW'(LEAD_BITS);
  localparam logic [BW-1:0] SHIFT_LAST  = BW'(LEAD_BITS + WIDTH - 1);

  if ((LEAD_BITS + WIDTH > FRAME_BITS) || (CLK_DIV < 1) || (WIDTH < 2) ||
      (QUIET_PERIODS < 1)) begin : g_param_check
    $error("adc_serial_capture: illegal parameter combination");
  end

  state_t           state;
  logic [QW-1:0]    quiet_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;

  logic sclk_en;
  logic rise_tick;
  logic period_tick;
  logic quiet_done;
  logic frame_done;
  logic in_window;

  always_comb begin
    quiet_done = (state == QUIET) && (quiet_cnt == QUIET_LAST);
    frame_done = (state == CONVERT) && period_tick && (bit_cnt == BIT_LAST);
    sclk_en    = quiet_done || ((state == CONVERT) && !frame_done);
    in_window  = (bit_cnt >= SHIFT_FIRST) && (bit_cnt <= SHIFT_LAST);
  end

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk        (clk),
    .reset      (reset),
    .enable     (sclk_en),
    .adc_clk    (adc_clk),
    .rise_tick  (rise_tick),
    .period_tick(period_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= QUIET;
      quiet_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      ready     <= 1'b0;
      adc_cs    <= 1'b1;
    end else begin
      ready <= 1'b0;
      case (state)
        QUIET: begin
          if (quiet_done) begin
            state     <= CONVERT;
            quiet_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            adc_cs    <= 1'b0;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        CONVERT: begin
          if (rise_tick && in_window) begin
            shreg <= {shreg[WIDTH-2:0], adc_sd};
          end
          if (period_tick) begin
            if (bit_cnt == BIT_LAST) begin
              state  <= QUIET;
              adc_cs <= 1'b1;
              ready  <= 1'b1;
              data   <= shreg;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= QUIET;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: ADC word model, frame-level reference model
// and a table of directed frames plus reset corner cases.
module tb_adc_serial_capture;

  localparam int WIDTH      = 12;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int READY_GAP  = 80;
  localparam int CS_LOW     = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        adc_sd = 1'b0;
  logic        adc_clk;
  logic        adc_cs;
  logic [11:0] data;
  logic        ready;

  int checks = 0;
  int errors = 0;

  adc_serial_capture #(
    .WIDTH        (12),
    .FRAME_BITS   (16),
    .LEAD_BITS    (4),
    .CLK_DIV      (2),
    .QUIET_PERIODS(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .adc_sd (adc_sd),
    .adc_clk(adc_clk),
    .adc_cs (adc_cs),
    .data   (data),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample carried by a frame word: bits after the lead field, MSB first.
  function automatic logic [11:0] sample_of(input logic [15:0] w);
    return 12'((w >> (FRAME_BITS - LEAD_BITS - WIDTH)) & 16'h0FFF);
  endfunction

  // ADC model: one word per chip-select window, bits change on adc_clk falls.
  logic [15:0] tx_q[$];
  logic [15:0] sent_q[$];
  logic [15:0] cur_word = '0;
  int          bit_idx = 0;

  always @(negedge adc_cs) begin
    cur_word = (tx_q.size() != 0) ? tx_q.pop_front() : 16'($urandom);
    sent_q.push_back(cur_word);
    bit_idx = 0;
  end

  always @(negedge adc_clk) begin
    #1;
    if (!adc_cs && bit_idx < FRAME_BITS) begin
      adc_sd = cur_word[FRAME_BITS-1-bit_idx];
      bit_idx++;
    end
  end

  always @(posedge clk) begin
    if (adc_cs) adc_sd = 1'($urandom);
  end

  // Frame-level monitor and reference model.
  int          cyc = 0;
  int          last_ready = 0;
  int          cs_low = 0;
  int          rises = 0;
  logic        prev_ready = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [11:0] exp_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sent_q.delete();
      exp_data   = '0;
      last_ready = cyc;
      prev_ready = 1'b0;
      prev_cs    = 1'b1;
      prev_sclk  = 1'b1;
      cs_low     = 0;
      rises      = 0;
    end else begin
      if (ready) begin
        check("ready_width", 32'(prev_ready), 0);
        check("ready_interval", cyc - last_ready, READY_GAP);
        last_ready = cyc;
        check("frames_pending", sent_q.size(), 1);
        if (sent_q.size() != 0) exp_data = sample_of(sent_q.pop_front());
        check("data_model", data, exp_data);
      end else begin
        check("data_hold", data, exp_data);
      end
      if (!adc_cs) begin
        cs_low++;
        if (adc_clk && !prev_sclk) rises++;
      end else begin
        check("sclk_idle", 32'(adc_clk), 1);
        if (!prev_cs) begin
          check("cs_low_len", cs_low, CS_LOW);
          check("sclk_rises", rises, FRAME_BITS);
          cs_low = 0;
          rises  = 0;
        end
      end
      prev_ready = ready;
      prev_cs    = adc_cs;
      prev_sclk  = adc_clk;
    end
  end

  task automatic wait_ready(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cs"}, 32'(adc_cs), 1);
    check({name, "_sclk"}, 32'(adc_clk), 1);
    check({name, "_ready"}, 32'(ready), 0);
    check({name, "_data"}, data, 0);
  endtask

  typedef struct {
    logic [3:0]  lead;
    logic [11:0] sample;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int rel_cyc;
    int r;
    logic pclk;

    tbl[0] = '{4'h0, 12'hABC, 12'hABC};
    tbl[1] = '{4'hF, 12'h000, 12'h000};
    tbl[2] = '{4'h0, 12'hFFF, 12'hFFF};
    tbl[3] = '{4'hA, 12'h800, 12'h800};
    tbl[4] = '{4'h5, 12'h001, 12'h001};
    tbl[5] = '{4'h3, 12'h7E1, 12'h7E1};

    // Reset takes effect without any clock edge.
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_async");
    foreach (tbl[i]) tx_q.push_back({tbl[i].lead, tbl[i].sample});
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_outputs("reset_hold");
    end
    @(negedge clk);
    #2 reset = 1'b0;

    foreach (tbl[i]) begin
      wait_ready("ready_table");
      check("table_data", data, tbl[i].exp);
    end

    // Reset in the middle of a random frame, between clock edges.
    repeat (30) @(negedge clk);
    check("cs_low_before_reset", 32'(adc_cs), 0);
    #3 reset = 1'b1;
    #1 check_reset_outputs("reset_midcycle");
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_outputs("reset_midcycle_hold");
    end

    // Abort a 12'h5A5 frame after 8 sampled bits.
    tx_q.delete();
    tx_q.push_back({4'h0, 12'h5A5});
    @(negedge clk);
    #2 reset = 1'b0;
    r = 0;
    pclk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!adc_cs && adc_clk && !pclk) r++;
      pclk = adc_clk;
      if (r == 8) break;
    end
    check("abort_bits_seen", r, 8);
    #1 reset = 1'b1;
    #1 check_reset_outputs("abort");
    tx_q.push_back({4'h0, 12'h123});
    repeat (4) begin
      @(negedge clk);
      #1 check("abort_no_ready", 32'(ready), 0);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    rel_cyc = cyc;
    wait_ready("ready_after_abort");
    check("abort_release_gap", cyc - rel_cyc, READY_GAP);
    check("abort_next_data", data, 12'h123);

    // Back-to-back random frames checked by the monitor.
    for (int i = 0; i < 10; i++) wait_ready("ready_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t expected < 200000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
- Serial-ADC front end for the spectrum-analyser datapath. Sits between the external 12-bit SPI-style ADC (AD7476/ADCS7476 class) and the FFT input.
- Generates chip-select and serial clock, shifts in one frame per conversion, and presents a parallel sample.
- Emits a one-clock `ready` strobe that the FFT core uses directly as its clock enable.

Parameters:
- WIDTH, 12: sample width in bits.
- FRAME_BITS, 16: adc_clk periods per conversion, with adc_cs low.
- LEAD_BITS, 4: leading bits of each frame that are discarded.
- CLK_DIV, 2: adc_clk half-period, in clk cycles. Must be >= 1.
- QUIET_PERIODS, 4: adc_clk periods with adc_cs high between frames.
- Elaboration check: LEAD_BITS + WIDTH <= FRAME_BITS.

Ports:
- clk  input  1  system clock (32 MHz from the PLL).
- reset  input  1  asynchronous, active-high reset.
- adc_sd  input  1  serial data from the ADC, MSB first.
- adc_clk  output  1  serial clock to the ADC.
- adc_cs  output  1  chip select, active low.
- data  output  WIDTH  last captured sample, unsigned.
- ready  output  1  single-cycle strobe: `data` was updated this cycle.

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset values, applied immediately on assertion:
  - adc_cs=1, adc_clk=1, ready=0, data=0.
  - State QUIET, with all counters at 0.
- Period P = 2*CLK_DIV clk cycles.
- State QUIET:
  - adc_cs=1, adc_clk=1.
  - Lasts QUIET_PERIODS*P cycles, then goes to CONVERT.
- State CONVERT:
  - adc_cs=0 for exactly FRAME_BITS*P cycles.
  - Each period: adc_clk low for the first CLK_DIV cycles, then high for the next CLK_DIV cycles.
  - adc_sd is sampled on the clk edge at which adc_clk goes 0->1, i.e. one sample per period and FRAME_BITS samples per frame.
- Bit use within a frame:
  - Samples 0..LEAD_BITS-1 are discarded.
  - Samples LEAD_BITS..LEAD_BITS+WIDTH-1 are shifted in, MSB first.
  - Any remaining samples are ignored.
- End of CONVERT:
  - Return to QUIET with adc_cs=1 and adc_clk=1.
  - In that same first QUIET cycle: data <= shift register and ready=1 for exactly one cycle.
- data holds its value until the next ready strobe.
- Throughput: the ready interval is exactly (QUIET_PERIODS+FRAME_BITS)*P clk cycles. With defaults this is 80 cycles, i.e. 400 kS/s at 32 MHz.
- The first frame after reset release begins with a full QUIET interval.
- Reset during CONVERT:
  - The frame is aborted and adc_cs returns high at once.
  - No ready strobe is issued for the aborted frame, and data is cleared to 0.
- adc_sd is not synchronised beyond the sampling register; the ADC timing guarantees setup.
- The shift register and counters size themselves from the parameters with $clog2.

Decomposition:
- Shared package adc_pkg:
  - State enum {QUIET, CONVERT}.
  - Default constants for WIDTH, FRAME_BITS, LEAD_BITS, CLK_DIV and QUIET_PERIODS.
  - Derived constant for the period P.
- One natural sub-module, adc_sclk_gen:
  - Runs the half-period counter and produces adc_clk.
  - Outputs a one-cycle rise_tick (sample point) and a period_tick (end of period).
  - Has an enable input; when disabled it holds adc_clk high.
- The FSM, bit counter and shift register remain in adc_serial_capture.

Test Plan:
- Reset: assert reset mid-cycle -> adc_cs=1, adc_clk=1, ready=0 and data=0 with no clock edge needed; they stay so while reset is held.
- Basic frame: bench ADC model drives 4'b0000 then 12'hABC MSB first, changing adc_sd on adc_clk falling edges -> one ready pulse with data=12'hABC; adc_cs low for exactly 64 clk cycles.
- Lead bits ignored: drive 4'b1111 followed by 12'h000, then a frame of 4'b0000 followed by 12'hFFF -> data=12'h000, then data=12'hFFF.
- Timing: 10 consecutive frames -> ready pulses exactly 80 cycles apart, each 1 cycle wide; 16 adc_clk rising edges per adc_cs-low window and none while adc_cs is high.
- Mid-frame reset: assert reset after 8 bits of a 12'h5A5 frame -> adc_cs goes high at once and no ready appears. After release, the next full frame of 12'h123 gives data=12'h123, with ready 80 cycles after release.
- Hold: between strobes, adc_sd toggles randomly while adc_cs is high -> data stays unchanged.
